// File: rtl/traffic_ctrl.sv
// Traffic light phase controller: steps a one-hot phase through a fixed sequence
// on per-phase timer expiry, with hold, pedestrian walk, cycle counting and fault flag.
module traffic_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] done_state,
    input  logic       hold,
    input  logic       ped_req,
    output logic [6:0] curr_state,
    output logic       dp_cnt_rst,
    output logic       ped_walk,
    output logic [7:0] cycle_cnt,
    output logic       err
);

    typedef enum logic [6:0] {
        G1    = 7'b0000001,
        NONE1 = 7'b0000010,
        G2    = 7'b0000100,
        NONE2 = 7'b0001000,
        G3    = 7'b0010000,
        Y     = 7'b0100000,
        R     = 7'b1000000
    } state_e;

    state_e     state_q, state_d;
    logic       first_q;
    logic       ped_pend_q, ped_pend_d;
    logic       ped_walk_q, ped_walk_d;
    logic [7:0] cycle_cnt_q, cycle_cnt_d;
    logic       err_q, err_d;
    logic       onehot;
    logic       adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= G1;
            first_q     <= 1'b1;
            ped_pend_q  <= 1'b0;
            ped_walk_q  <= 1'b0;
            cycle_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= 1'b0;
            ped_pend_q  <= ped_pend_d;
            ped_walk_q  <= ped_walk_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        onehot      = $onehot(state_q);
        // Only the current phase's own done bit may advance it
        adv         = onehot && !first_q && !hold && (|(done_state & state_q));
        state_d     = state_q;
        ped_pend_d  = ped_pend_q | ped_req;
        ped_walk_d  = ped_walk_q;
        cycle_cnt_d = cycle_cnt_q;
        err_d       = err_q | !onehot | (!first_q && (|(done_state & ~state_q)));
        dp_cnt_rst  = adv | hold | rst | first_q | !onehot;

        if (!onehot) begin
            state_d    = R;
            ped_walk_d = 1'b0;
        end else if (adv) begin
            case (state_q)
                G1:    state_d = NONE1;
                NONE1: state_d = G2;
                G2:    state_d = NONE2;
                NONE2: state_d = G3;
                G3:    state_d = Y;
                Y: begin
                    state_d    = R;
                    ped_walk_d = ped_pend_q | ped_req;
                    ped_pend_d = 1'b0;
                end
                R: begin
                    state_d     = G1;
                    ped_walk_d  = 1'b0;
                    cycle_cnt_d = cycle_cnt_q + 8'd1;
                end
                default: state_d = R;
            endcase
        end
    end

    assign curr_state = state_q;
    assign ped_walk   = ped_walk_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_traffic_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] done_state;
    logic       hold;
    logic       ped_req;
    logic [6:0] curr_state;
    logic       dp_cnt_rst;
    logic       ped_walk;
    logic [7:0] cycle_cnt;
    logic       err;

    typedef struct {
        logic [6:0] st;
        logic       dp;
        logic       pw;
        logic [7:0] cc;
        logic       er;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] cc_exp = 8'd0;
    logic [6:0] ph [7] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40};

    traffic_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .done_state (done_state),
        .hold       (hold),
        .ped_req    (ped_req),
        .curr_state (curr_state),
        .dp_cnt_rst (dp_cnt_rst),
        .ped_walk   (ped_walk),
        .cycle_cnt  (cycle_cnt),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input string fld, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", name, fld, act, expv);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "curr_state", {1'b0, curr_state}, {1'b0, e.st});
            chk(e.name, "dp_cnt_rst", {7'd0, dp_cnt_rst}, {7'd0, e.dp});
            chk(e.name, "ped_walk",   {7'd0, ped_walk},   {7'd0, e.pw});
            chk(e.name, "cycle_cnt",  cycle_cnt,          e.cc);
            chk(e.name, "err",        {7'd0, err},        {7'd0, e.er});
        end
    end

    // Drive one cycle of inputs, queue what the outputs must be in that cycle
    task automatic cyc(input logic [6:0] ds, input logic h, input logic pr,
                       input logic [6:0] st, input logic dp, input logic pw,
                       input logic [7:0] cc, input logic er, input string name);
        exp_t e;
        done_state = ds;
        hold       = h;
        ped_req    = pr;
        e.st = st; e.dp = dp; e.pw = pw; e.cc = cc; e.er = er; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One full light cycle from G1, pulsing each phase's done bit once
    task automatic run_cycle(input logic walk, input logic pr_in_r, input string name);
        for (int k = 0; k < 7; k++) begin
            cyc(ph[k], 1'b0, (k == 6) ? pr_in_r : 1'b0, ph[k], 1'b1,
                (k == 6) ? walk : 1'b0, cc_exp, 1'b0, name);
        end
        cc_exp = cc_exp + 8'd1;
    endtask

    initial begin
        rst = 1'b1; done_state = '0; hold = 1'b0; ped_req = 1'b0;
        @(posedge clk); #1;
        cyc(7'h00, 0, 0, 7'h01, 1, 0, 8'd0, 0, "reset");
        rst = 1'b0;

        // First cycle after release ignores done; advance only at the second edge
        cyc(7'h01, 0, 0, 7'h01, 1, 0, 8'd0, 0, "first_cycle");
        cyc(7'h01, 0, 0, 7'h01, 1, 0, 8'd0, 0, "g1_adv");
        cyc(7'h02, 0, 0, 7'h02, 1, 0, 8'd0, 0, "none1_adv");
        cyc(7'h00, 0, 0, 7'h04, 0, 0, 8'd0, 0, "g2_idle");
        for (int i = 0; i < 5; i++)
            cyc(7'h04, 1, 0, 7'h04, 1, 0, 8'd0, 0, "g2_hold");
        cyc(7'h04, 0, 0, 7'h04, 1, 0, 8'd0, 0, "g2_release");
        cyc(7'h08, 0, 0, 7'h08, 1, 0, 8'd0, 0, "none2_adv");
        cyc(7'h00, 0, 1, 7'h10, 0, 0, 8'd0, 0, "g3_ped");
        cyc(7'h10, 0, 0, 7'h10, 1, 0, 8'd0, 0, "g3_adv");
        cyc(7'h20, 0, 0, 7'h20, 1, 0, 8'd0, 0, "y_adv");
        cyc(7'h00, 0, 0, 7'h40, 0, 1, 8'd0, 0, "r_walk");
        cyc(7'h40, 0, 0, 7'h40, 1, 1, 8'd0, 0, "r_adv");
        cc_exp = 8'd1;
        cyc(7'h00, 0, 0, 7'h01, 0, 0, 8'd1, 0, "g1_after_cycle");

        run_cycle(1'b0, 1'b0, "no_walk");
        run_cycle(1'b0, 1'b1, "req_in_r");
        run_cycle(1'b1, 1'b0, "walk_from_r_req");
        run_cycle(1'b0, 1'b0, "walk_cleared");

        for (int i = 0; i < 256; i++)
            run_cycle(1'b0, 1'b0, "wrap_run");
        cyc(7'h00, 0, 0, 7'h01, 0, 0, cc_exp, 0, "after_wrap");

        // Walk to Y, then assert reset mid-cycle
        for (int k = 0; k < 5; k++)
            cyc(ph[k], 0, 0, ph[k], 1, 0, cc_exp, 0, "to_y");
        begin
            exp_t e;
            done_state = '0;
            e.st = 7'h01; e.dp = 1'b1; e.pw = 1'b0; e.cc = 8'd0; e.er = 1'b0; e.name = "async_rst_in_y";
            q.push_back(e);
            #2 rst = 1'b1;
            @(posedge clk); #1;
        end
        cc_exp = 8'd0;
        cyc(7'h00, 0, 0, 7'h01, 1, 0, 8'd0, 0, "rst_held");
        rst = 1'b0;

        // Stray done bits: ignored in the first cycle, fault afterwards
        cyc(7'h40, 0, 0, 7'h01, 1, 0, 8'd0, 0, "first_cycle_stray");
        cyc(7'h00, 0, 0, 7'h01, 0, 0, 8'd0, 0, "no_err_after_first");
        cyc(7'h40, 0, 0, 7'h01, 0, 0, 8'd0, 0, "stray_done");
        cyc(7'h00, 0, 0, 7'h01, 0, 0, 8'd0, 1, "err_set");
        cyc(7'h01, 0, 0, 7'h01, 1, 0, 8'd0, 1, "err_sticky_adv");
        cyc(7'h00, 0, 0, 7'h02, 0, 0, 8'd0, 1, "err_sticky");
        rst = 1'b1;
        cyc(7'h00, 0, 0, 7'h01, 1, 0, 8'd0, 0, "err_cleared");
        rst = 1'b0;

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
